// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the bus control unit: state encoding,
// opcode values and instruction-register field positions.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    localparam int NREG = 8;
    localparam int IR_W = 9;

    localparam int IR_OP_HI = 8;
    localparam int IR_OP_LO = 6;
    localparam int IR_X_HI  = 5;
    localparam int IR_X_LO  = 3;
    localparam int IR_Y_HI  = 2;
    localparam int IR_Y_LO  = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    function automatic logic op_illegal(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot select; all-zero when not enabled.
module reg_sel_decoder
    import bus_ctrl_pkg::*;
(
    input  logic [2:0]      idx,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en)
            onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/bus_control_fsm.sv
// Four-step control FSM for the shared processor bus (mv, mvi, add, sub).
// Optional ILLEGAL_OP_FLAG_EN adds IllegalOp pulse and IllegalSticky outputs.
module bus_control_fsm
    import bus_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              IRin,
    output logic [NREG-1:0]   Rout,
    output logic              Gout,
    output logic              DINout,
    output logic [NREG-1:0]   Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
`ifdef ILLEGAL_OP_FLAG_EN
    output logic              Done,
    output logic              IllegalOp,
    output logic              IllegalSticky
`else
    output logic              Done
`endif
);

    state_t          state, state_n;
    logic [IR_W-1:0] ir;
    logic [2:0]      op, rx, ry;
    logic [2:0]      rout_idx, rin_idx;
    logic            rout_en, rin_en;
    logic            unused_din;

    assign op = ir[IR_OP_HI:IR_OP_LO];
    assign rx = ir[IR_X_HI:IR_X_LO];
    assign ry = ir[IR_Y_HI:IR_Y_LO];

    // Only the top nine bits carry the instruction.
    assign unused_din = ^DIN[DATA_W-IR_W-1:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_n;
            if (state == T0 && Run)
                ir <= DIN[DATA_W-1 -: IR_W];
        end
    end

    always_comb begin
        state_n  = state;
        IRin     = 1'b0;
        rout_en  = 1'b0;
        rout_idx = ry;
        rin_en   = 1'b0;
        rin_idx  = rx;
        Gout     = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        AddSub   = 1'b0;
        Done     = 1'b0;
        case (state)
            T0: begin
                if (Run) begin
                    IRin    = 1'b1;
                    state_n = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                        state_n = T0;
                    end
                    OP_MVI: begin
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                        state_n = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_idx = rx;
                        rout_en  = 1'b1;
                        Ain      = 1'b1;
                        state_n  = T2;
                    end
                    default: begin
                        Done    = 1'b1;
                        state_n = T0;
                    end
                endcase
            end
            T2: begin
                rout_en = 1'b1;
                Gin     = 1'b1;
                AddSub  = op[0];
                state_n = T3;
            end
            T3: begin
                Gout    = 1'b1;
                rin_en  = 1'b1;
                Done    = 1'b1;
                state_n = T0;
            end
            default: state_n = T0;
        endcase
        // Reset overrides everything so an aborted instruction never writes back.
        if (Reset) begin
            state_n = T0;
            IRin    = 1'b0;
            rout_en = 1'b0;
            rin_en  = 1'b0;
            Gout    = 1'b0;
            Ain     = 1'b0;
            Gin     = 1'b0;
            AddSub  = 1'b0;
            Done    = 1'b0;
        end
    end

    // DIN drives the bus whenever neither a register nor G does: one-hot by construction.
    assign DINout = ~(rout_en | Gout);

    reg_sel_decoder u_rout_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (Rout)
    );

    reg_sel_decoder u_rin_dec (
        .idx    (rin_idx),
        .en     (rin_en),
        .onehot (Rin)
    );

`ifdef ILLEGAL_OP_FLAG_EN
    assign IllegalOp = (state == T1) && op_illegal(op) && !Reset;

    always_ff @(posedge Clock) begin
        if (Reset)
            IllegalSticky <= 1'b0;
        else if (IllegalOp)
            IllegalSticky <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_bus_control_fsm.sv
// Directed vector table plus a random-stream invariant check for bus_control_fsm.
module tb_bus_control_fsm;

    logic        Clock = 1'b0;
    logic        Reset, Run;
    logic [15:0] DIN;
    logic        IRin, Gout, DINout, Ain, Gin, AddSub, Done;
    logic [7:0]  Rout, Rin;
`ifdef ILLEGAL_OP_FLAG_EN
    logic        IllegalOp, IllegalSticky;
`endif

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    bus_control_fsm #(.DATA_W(16)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Run           (Run),
        .DIN           (DIN),
        .IRin          (IRin),
        .Rout          (Rout),
        .Gout          (Gout),
        .DINout        (DINout),
        .Rin           (Rin),
        .Ain           (Ain),
        .Gin           (Gin),
        .AddSub        (AddSub),
`ifdef ILLEGAL_OP_FLAG_EN
        .Done          (Done),
        .IllegalOp     (IllegalOp),
        .IllegalSticky (IllegalSticky)
`else
        .Done          (Done)
`endif
    );

    typedef struct {
        logic        reset;
        logic        run;
        logic [15:0] din;
        logic [22:0] exp;   // {IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
        return {op, x, y, 7'b0};
    endfunction

    task automatic row(input logic rst, input logic run, input logic [15:0] din,
                       input logic irin, input logic [7:0] rout, input logic gout,
                       input logic dinout, input logic [7:0] rin, input logic ain,
                       input logic gin, input logic addsub, input logic done);
        vec_t v;
        v.reset = rst;
        v.run   = run;
        v.din   = din;
        v.exp   = {irin, rout, gout, dinout, rin, ain, gin, addsub, done};
        vecs.push_back(v);
    endtask

    task automatic step_check(input string name, input logic [22:0] exp);
        logic [22:0] got;
        @(negedge Clock);
        got = {IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b1;
        DIN   = 16'hFFFF;

        // rst run din                irin rout   gout dino rin    ain gin as done
        row(1, 1, 16'hFFFF,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // reset + Run
        row(1, 1, 16'hFFFF,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0);
        row(0, 0, 16'h0000,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // T0 idle
        row(0, 1, mk(3'd0, 3'd3, 3'd5),1, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // mv R3,R5
        row(0, 0, 16'h0000,            0, 8'h20, 0, 0, 8'h08, 0, 0, 0, 1);
        row(0, 0, 16'h0000,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0);
        row(0, 1, mk(3'd1, 3'd2, 3'd0),1, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // mvi R2
        row(0, 0, 16'h1234,            0, 8'h00, 0, 1, 8'h04, 0, 0, 0, 1);
        row(0, 1, mk(3'd3, 3'd1, 3'd6),1, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // sub R1,R6
        row(0, 1, 16'hFFFF,            0, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0);
        row(0, 1, 16'hFFFF,            0, 8'h40, 0, 0, 8'h00, 0, 1, 1, 0);
        row(0, 1, 16'hFFFF,            0, 8'h00, 1, 0, 8'h02, 0, 0, 0, 1);
        row(0, 0, 16'h0000,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0);
        row(0, 1, mk(3'd2, 3'd4, 3'd7),1, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // add R4,R7
        row(0, 0, 16'h0000,            0, 8'h10, 0, 0, 8'h00, 1, 0, 0, 0);
        row(0, 0, 16'h0000,            0, 8'h80, 0, 0, 8'h00, 0, 1, 0, 0);
        row(0, 0, 16'h0000,            0, 8'h00, 1, 0, 8'h10, 0, 0, 0, 1);
        row(0, 1, mk(3'd5, 3'd1, 3'd2),1, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // illegal 101
        row(0, 0, 16'h0000,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 1);
        row(0, 1, mk(3'd0, 3'd0, 3'd0),1, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // mv R0,R0
        row(0, 0, 16'h0000,            0, 8'h01, 0, 0, 8'h01, 0, 0, 0, 1);
        row(1, 1, mk(3'd2, 3'd1, 3'd1),0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // Run+Reset
        row(0, 0, 16'h0000,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0);
        row(0, 1, mk(3'd2, 3'd3, 3'd4),1, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // add, aborted in T2
        row(0, 0, 16'h0000,            0, 8'h08, 0, 0, 8'h00, 1, 0, 0, 0);
        row(1, 0, 16'h0000,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0);
        row(0, 0, 16'h0000,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0);
        row(0, 1, mk(3'd0, 3'd6, 3'd1),1, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0); // mv R6,R1
        row(0, 0, 16'h0000,            0, 8'h02, 0, 0, 8'h40, 0, 0, 0, 1);
        row(0, 0, 16'h0000,            0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            Reset = vecs[i].reset;
            Run   = vecs[i].run;
            DIN   = vecs[i].din;
            step_check($sformatf("vec%0d", i), vecs[i].exp);
        end

`ifdef ILLEGAL_OP_FLAG_EN
        // Illegal opcode: one-cycle pulse, sticky until reset.
        Reset = 1'b0; Run = 1'b1; DIN = mk(3'd5, 3'd0, 3'd0);
        @(negedge Clock); @(posedge Clock); #1;
        Run = 1'b0;
        @(negedge Clock);
        checks++;
        if (IllegalOp !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %b expected 1", IllegalOp); end
        @(posedge Clock); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            checks++;
            if (IllegalOp !== 1'b0 || IllegalSticky !== 1'b1) begin
                errors++;
                $display("FAIL illegal_sticky%0d: got op=%b sticky=%b expected op=0 sticky=1", k, IllegalOp, IllegalSticky);
            end
            @(posedge Clock); #1;
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (IllegalSticky !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b expected 0", IllegalSticky); end
        @(posedge Clock); #1;
`endif

        // Random stream: bus source stays one-hot, Rin zero- or one-hot.
        for (int c = 0; c < 10000; c++) begin
            Reset = ($urandom_range(0, 31) == 0);
            Run   = $urandom_range(0, 1) == 1;
            DIN   = 16'($urandom);
            @(negedge Clock);
            checks++;
            if ($countones({Rout, Gout, DINout}) != 1 || $countones(Rin) > 1) begin
                errors++;
                $display("FAIL onehot c%0d: got src=%b rin=%b expected one source, <=1 rin",
                         c, {Rout, Gout, DINout}, Rin);
            end
            @(posedge Clock); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
